// File: rtl/dmem_axi_bridge.sv
// Data-side bridge between the cpu load/store port and an AXI4-Lite slave.
// One transfer at a time; a simultaneous load+store runs the store first, then the load.
module dmem_axi_bridge #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter logic [2:0]  PROT   = 3'b000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      address,
    input  logic                   read_enable,
    output logic [DATA_W-1:0]      read_data,
    output logic                   read_valid,
    input  logic                   write_enable,
    input  logic [DATA_W-1:0]      write_data,
    input  logic [DATA_W/8-1:0]    write_wstrb,
    output logic                   write_done,
    output logic                   busy,
    output logic                   bus_error,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [ADDR_W-1:0]      araddr,
    output logic [2:0]             arprot,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [DATA_W-1:0]      rdata,
    input  logic [1:0]             rresp,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [ADDR_W-1:0]      awaddr,
    output logic [2:0]             awprot,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [DATA_W-1:0]      wdata,
    output logic [DATA_W/8-1:0]    wstrb,
    input  logic                   bvalid,
    output logic                   bready,
    input  logic [1:0]             bresp
);
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_D = 3'd2,
        WR   = 3'd3,
        WR_B = 3'd4
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } req_t;

    state_t            state, state_nxt;
    req_t              req_q, req_nxt;
    logic              pend_rd_q, pend_rd_nxt;
    logic [DATA_W-1:0] read_data_nxt;
    logic              read_valid_nxt, write_done_nxt, bus_error_nxt, busy_nxt;
    logic              arvalid_nxt, rready_nxt, awvalid_nxt, wvalid_nxt, bready_nxt;
    logic              aw_open, w_open;

    // An address or data beat is still owed while its valid is up without its ready.
    assign aw_open = awvalid && !awready;
    assign w_open  = wvalid && !wready;

    assign araddr = req_q.addr;
    assign awaddr = req_q.addr;
    assign wdata  = req_q.data;
    assign wstrb  = req_q.strb;
    assign arprot = PROT;
    assign awprot = PROT;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= '0;
            pend_rd_q  <= 1'b0;
            read_data  <= '0;
            read_valid <= 1'b0;
            write_done <= 1'b0;
            bus_error  <= 1'b0;
            busy       <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
        end else begin
            state      <= state_nxt;
            req_q      <= req_nxt;
            pend_rd_q  <= pend_rd_nxt;
            read_data  <= read_data_nxt;
            read_valid <= read_valid_nxt;
            write_done <= write_done_nxt;
            bus_error  <= bus_error_nxt;
            busy       <= busy_nxt;
            arvalid    <= arvalid_nxt;
            rready     <= rready_nxt;
            awvalid    <= awvalid_nxt;
            wvalid     <= wvalid_nxt;
            bready     <= bready_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (write_enable)     state_nxt = WR;
                else if (read_enable) state_nxt = RD_A;
            end
            RD_A: if (arvalid && arready) state_nxt = RD_D;
            RD_D: if (rvalid)             state_nxt = IDLE;
            WR:   if (!aw_open && !w_open) state_nxt = WR_B;
            WR_B: if (bvalid)             state_nxt = pend_rd_q ? RD_A : IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and the captured request.
    always_comb begin
        req_nxt        = req_q;
        pend_rd_nxt    = pend_rd_q;
        read_data_nxt  = read_data;
        read_valid_nxt = 1'b0;
        write_done_nxt = 1'b0;
        bus_error_nxt  = 1'b0;
        awvalid_nxt    = 1'b0;
        wvalid_nxt     = 1'b0;
        arvalid_nxt    = (state_nxt == RD_A);
        rready_nxt     = (state_nxt == RD_D);
        bready_nxt     = (state_nxt == WR_B);
        busy_nxt       = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (write_enable || read_enable) begin
                    req_nxt     = '{addr: address, data: write_data, strb: write_wstrb};
                    pend_rd_nxt = write_enable && read_enable;
                    awvalid_nxt = write_enable;
                    wvalid_nxt  = write_enable;
                end
            end
            RD_D: begin
                if (rvalid) begin
                    read_data_nxt  = rdata;
                    read_valid_nxt = 1'b1;
                    bus_error_nxt  = (rresp != 2'b00);
                end
            end
            WR: begin
                awvalid_nxt = aw_open;
                wvalid_nxt  = w_open;
            end
            WR_B: begin
                if (bvalid) begin
                    write_done_nxt = 1'b1;
                    bus_error_nxt  = (bresp != 2'b00);
                    pend_rd_nxt    = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Bench for dmem_axi_bridge: AXI4-Lite slave with tunable stalls, a reference memory
// and an in-order completion queue checked every cycle, plus directed scenario checks.
module tb_dmem_axi_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        read_enable;
    logic [31:0] read_data;
    logic        read_valid;
    logic        write_enable;
    logic [31:0] write_data;
    logic [3:0]  write_wstrb;
    logic        write_done, busy, bus_error;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] araddr, rdata;
    logic [2:0]  arprot, awprot;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;

    dmem_axi_bridge #(.ADDR_W(32), .DATA_W(32), .PROT(3'b000)) dut (
        .clk(clk), .reset(reset),
        .address(address), .read_enable(read_enable), .read_data(read_data),
        .read_valid(read_valid), .write_enable(write_enable), .write_data(write_data),
        .write_wstrb(write_wstrb), .write_done(write_done), .busy(busy), .bus_error(bus_error),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] preload(input int idx);
        if (idx == 32'h40) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 | 32'(idx);
    endfunction

    // ---------------- AXI4-Lite slave ----------------
    bit          rand_stall = 1'b0;
    int          rd_lat = 0;
    int          aw_wait = 0;
    bit          err_rd = 1'b0;
    bit          mem_loaded = 1'b0;
    logic [31:0] slv_mem [0:1023];
    bit          ar_rnd;
    bit          r_pend;
    int          r_cnt, s_lat, aw_cnt;
    logic [31:0] r_addr;
    bit          have_aw, have_w, got_aw, got_w;
    logic [31:0] s_awaddr, s_wdata, s_a, s_d, s_word;
    logic [3:0]  s_wstrb, s_s;
    int          ar_hs_n = 0, aw_hs_n = 0, w_hs_n = 0;

    assign arready = rand_stall ? ar_rnd : 1'b1;
    assign awready = awvalid && (aw_cnt >= aw_wait);
    assign wready  = 1'b1;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) slv_mem[i] = preload(i);
            mem_loaded = 1'b1;
        end
        if (reset) begin
            rvalid <= 1'b0; bvalid <= 1'b0; r_pend <= 1'b0; ar_rnd <= 1'b0;
            have_aw <= 1'b0; have_w <= 1'b0; aw_cnt <= 0;
            rdata <= '0; rresp <= 2'b00; bresp <= 2'b00;
        end else begin
            ar_rnd <= 1'($urandom_range(0, 1));
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                ar_hs_n <= ar_hs_n + 1;
                s_lat = rand_stall ? int'($urandom_range(0, 3)) : rd_lat;
                r_addr <= araddr;
                if (s_lat == 0) begin
                    rvalid <= 1'b1; rdata <= slv_mem[araddr[11:2]];
                    rresp <= err_rd ? 2'b10 : 2'b00;
                end else begin
                    r_pend <= 1'b1; r_cnt <= s_lat;
                end
            end else if (r_pend) begin
                if (r_cnt == 1) begin
                    rvalid <= 1'b1; rdata <= slv_mem[r_addr[11:2]];
                    rresp <= err_rd ? 2'b10 : 2'b00; r_pend <= 1'b0;
                end
                r_cnt <= r_cnt - 1;
            end
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
            if (awvalid && awready) begin
                s_awaddr <= awaddr; aw_hs_n <= aw_hs_n + 1; aw_cnt <= 0;
            end
            if (wvalid && wready) begin
                s_wdata <= wdata; s_wstrb <= wstrb; w_hs_n <= w_hs_n + 1;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            got_aw = have_aw || (awvalid && awready);
            got_w  = have_w || (wvalid && wready);
            if (got_aw && got_w) begin
                s_a = (awvalid && awready) ? awaddr : s_awaddr;
                s_d = (wvalid && wready) ? wdata : s_wdata;
                s_s = (wvalid && wready) ? wstrb : s_wstrb;
                s_word = slv_mem[s_a[11:2]];
                for (int b = 0; b < 4; b++) if (s_s[b]) s_word[8*b +: 8] = s_d[8*b +: 8];
                slv_mem[s_a[11:2]] <= s_word;
                bvalid <= 1'b1; bresp <= 2'b00;
                have_aw <= 1'b0; have_w <= 1'b0;
            end else begin
                have_aw <= got_aw; have_w <= got_w;
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct { bit is_rd; logic [31:0] data; bit err; } exp_t;
    exp_t        expq[$];
    exp_t        cmp_e;
    logic [31:0] ref_mem [0:1023];
    int          wd_cnt = 0;
    bit          prev_arv, prev_arr, prev_awv, prev_awr, prev_wv, prev_wr;
    logic [31:0] prev_araddr, prev_awaddr, prev_wdata;

    // Completions must arrive in request order with the model's data and error flag.
    always @(negedge clk) begin
        if (reset) begin
            prev_arv = 1'b0; prev_awv = 1'b0; prev_wv = 1'b0;
        end else begin
            if (write_done) wd_cnt++;
            if (read_valid || write_done) begin
                if (expq.size() == 0) begin
                    chk("unexpected_completion", {read_valid, write_done}, 2'b00);
                end else begin
                    cmp_e = expq.pop_front();
                    chk("completion_kind", {read_valid, write_done}, cmp_e.is_rd ? 2'b10 : 2'b01);
                    if (cmp_e.is_rd) chk("load_data", read_data, cmp_e.data);
                    chk("bus_error", bus_error, cmp_e.err);
                end
            end else begin
                chk("bus_error_quiet", bus_error, 1'b0);
            end
            if (prev_arv && !prev_arr) chk("arvalid_held", {arvalid, araddr}, {1'b1, prev_araddr});
            if (prev_awv && !prev_awr) chk("awvalid_held", {awvalid, awaddr}, {1'b1, prev_awaddr});
            if (prev_wv && !prev_wr)   chk("wvalid_held", {wvalid, wdata}, {1'b1, prev_wdata});
            prev_arv = arvalid; prev_arr = arready; prev_araddr = araddr;
            prev_awv = awvalid; prev_awr = awready; prev_awaddr = awaddr;
            prev_wv  = wvalid;  prev_wr  = wready;  prev_wdata  = wdata;
        end
    end

    // ---------------- cpu driver ----------------
    task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit err, output int t0);
        address = a; read_enable = rd; write_enable = wr;
        write_data = d; write_wstrb = s; err_rd = err;
        t0 = cyc;
        if (wr) begin
            for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
            expq.push_back('{is_rd: 1'b0, data: 32'h0, err: 1'b0});
        end
        if (rd) expq.push_back('{is_rd: 1'b1, data: ref_mem[a[11:2]], err: err});
    endtask

    task automatic wait_done(input bit rd, output int tdone);
        tdone = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rd ? read_valid : write_done) begin
                tdone = cyc;
                break;
            end
        end
        if (tdone < 0) chk("completion_timeout", 1'b0, 1'b1);
    endtask

    task automatic drop();
        read_enable = 1'b0; write_enable = 1'b0;
    endtask

    function automatic logic [10:0] ctrl_vec();
        return {arvalid, rready, awvalid, wvalid, bready, read_valid, write_done,
                bus_error, busy, 2'b00};
    endfunction

    int t0, td, ar0, aw0, w0, wd0;
    bit busy_ok, saw_wd;
    logic [31:0] addrs [8];

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = preload(i);
        reset = 1'b1; drop(); address = '0; write_data = '0; write_wstrb = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", ctrl_vec(), 11'h0);
        chk("reset_read_data", read_data, 32'h0);
        chk("reset_axi_addr", {araddr, awaddr, wdata, wstrb}, 100'h0);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait load: request sampled on edge t0+1, arvalid the cycle after,
        // read_valid registered two edges after the sampling edge.
        ar0 = ar_hs_n;
        issue(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, t0);
        @(negedge clk);
        chk("t1_arvalid", {arvalid, araddr}, {1'b1, 32'h100});
        wait_done(1'b1, td);
        chk("t1_latency", td - t0, 3);
        chk("t1_data_literal", read_data, 32'hDEAD_BEEF);
        chk("t1_busy_at_pulse", busy, 1'b0);
        chk("t1_one_ar", ar_hs_n - ar0, 1);
        drop();

        // Store with awready lagging the write-data handshake by three cycles.
        aw_wait = 3; aw0 = aw_hs_n; w0 = w_hs_n; wd0 = wd_cnt;
        issue(1'b0, 1'b1, 32'h200, 32'h1234_5678, 4'b0011, 1'b0, t0);
        @(negedge clk);
        chk("t2_aw_w_raised", {awvalid, wvalid, awaddr, wdata, wstrb}, {2'b11, 32'h200, 32'h1234_5678, 4'b0011});
        @(negedge clk);
        chk("t2_w_dropped_aw_held", {awvalid, wvalid}, 2'b10);
        wait_done(1'b0, td);
        drop(); aw_wait = 0;
        repeat (3) @(negedge clk);
        chk("t2_single_done", wd_cnt - wd0, 1);
        chk("t2_single_aw_w", {16'(aw_hs_n - aw0), 16'(w_hs_n - w0)}, {16'd1, 16'd1});
        issue(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0, t0);
        wait_done(1'b1, td);
        chk("t2_readback_literal", read_data, 32'hC0DE_5678);
        drop();
        @(negedge clk);

        // Simultaneous load and store to one address: store first, load sees new data.
        issue(1'b1, 1'b1, 32'h300, 32'hA5A5_A5A5, 4'hF, 1'b0, t0);
        busy_ok = 1'b1; saw_wd = 1'b0; td = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (read_valid) begin td = cyc; break; end
            if (!busy) busy_ok = 1'b0;
            if (write_done) saw_wd = 1'b1;
        end
        chk("t3_completed", td >= 0, 1'b1);
        chk("t3_busy_throughout", busy_ok, 1'b1);
        chk("t3_write_done_first", saw_wd, 1'b1);
        chk("t3_data_literal", read_data, 32'hA5A5_A5A5);
        chk("t3_busy_at_pulse", busy, 1'b0);
        drop();
        @(negedge clk);

        // Load answered with SLVERR.
        issue(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 1'b1, t0);
        wait_done(1'b1, td);
        chk("t4_err_pulse", {read_valid, bus_error, busy}, 3'b110);
        chk("t4_err_data_literal", read_data, 32'hC0DE_0041);
        drop(); err_rd = 1'b0;
        @(negedge clk);
        chk("t4_idle_after", {busy, bus_error, read_valid, arvalid}, 4'b0000);

        // Back-to-back loads with random arready and rvalid stalls.
        rand_stall = 1'b1; ar0 = ar_hs_n;
        addrs = '{32'h100, 32'h200, 32'h300, 32'h104, 32'h3FC, 32'h000, 32'h208, 32'h100};
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 1'b0, addrs[i], 32'h0, 4'h0, 1'b0, t0);
            wait_done(1'b1, td);
        end
        drop();
        repeat (4) @(negedge clk);
        chk("t5_ar_count", ar_hs_n - ar0, 8);
        rand_stall = 1'b0;

        // Reset while waiting in the read-data phase.
        rd_lat = 20;
        issue(1'b1, 1'b0, 32'h108, 32'h0, 4'h0, 1'b0, t0);
        td = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rready) begin td = cyc; break; end
        end
        chk("t6_reached_rd_data", td >= 0, 1'b1);
        reset = 1'b1; drop(); expq.delete();
        @(negedge clk);
        chk("t6_reset_ctrl", ctrl_vec(), 11'h0);
        chk("t6_reset_data", {read_data, araddr}, 64'h0);
        reset = 1'b0; rd_lat = 0;
        @(negedge clk);
        issue(1'b1, 1'b0, 32'h10C, 32'h0, 4'h0, 1'b0, t0);
        wait_done(1'b1, td);
        chk("t6_after_reset_latency", td - t0, 3);
        chk("t6_after_reset_literal", read_data, 32'hC0DE_0043);
        drop();

        repeat (5) @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
